// File: rtl/flash_arb_pkg.sv
// Shared types for the flash access arbiter: default widths, FSM states and the latched command.
// Pure declarations; no timing or flow-control behaviour lives here.
package flash_arb_pkg;

    localparam int FLASH_ADDR_W = 4;
    localparam int FLASH_DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                    we;
        logic [FLASH_ADDR_W-1:0] addr;
        logic [FLASH_DATA_W-1:0] wdata;
        logic                    lock;
    } cmd_t;

endpackage

// File: rtl/flash_access_arbiter_if.sv
// Requester-side bus of the flash arbiter: request/lock/command in, grant/response pulses out.
// Requesters hold their command until gnt; responses are single-cycle pulses with no backpressure.
interface flash_access_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 256
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic                      err;
    logic [DATA_W-1:0]         rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/flash_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping; zero latency.
// No state and no backpressure; win_oh is all-zero when nothing is requested.
module rr_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]                               req,
    input  logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0]   ptr,
    output logic [NUM_REQ-1:0]                               win_oh,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0]   win_idx
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic found;
    int   j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// Round-robin, lockable arbiter sharing one 1-cycle-read flash RAM; gnt +1, rvalid +2 after IDLE sample.
// Requesters hold commands until gnt; FLASH_WP_EN adds write protection of addresses <= WP_TOP.
module flash_access_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = FLASH_ADDR_W,
    parameter int DATA_W   = FLASH_DATA_W,
    parameter int LOCK_MAX = 8,
    parameter int WP_TOP   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          max_address,
    flash_access_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic                       ram_we,
    output logic [DATA_W-1:0]          ram_wdata,
    input  logic [DATA_W-1:0]          ram_q
);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam logic [ADDR_W-1:0] WP_TOP_A = ADDR_W'(WP_TOP);
`ifdef FLASH_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    cmd_t               cmd_q, cmd_d;
    logic               ok_q, ok_d;
    logic [LCW-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [IW-1:0]      sel_idx;
    cmd_t               sel_cmd;
    logic               sel_ok;
    logic               lock_go;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    assign arb_any = |arb_oh;

    // In IDLE the fresh winner's command is sampled; in RESP the held winner may re-latch.
    always_comb begin
        sel_cmd       = '0;
        sel_idx       = (state_q == IDLE) ? arb_idx : win_q;
        sel_cmd.we    = bus.we[sel_idx];
        sel_cmd.addr  = bus.addr[sel_idx*ADDR_W +: ADDR_W];
        sel_cmd.wdata = bus.wdata[sel_idx*DATA_W +: DATA_W];
        sel_cmd.lock  = bus.lock[sel_idx];
        sel_ok        = (sel_cmd.addr <= max_address) &&
                        !(WP_ON && sel_cmd.we && (sel_cmd.addr <= WP_TOP_A));
    end

    assign lock_go = cmd_q.lock && bus.req[win_q] && (cnt_q < LCW'(LOCK_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cmd_q   <= '0;
            ok_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            ok_q    <= ok_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        ok_d    = ok_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = GRANT;
                    win_d   = arb_idx;
                    cmd_d   = sel_cmd;
                    ok_d    = sel_ok;
                    if (sel_cmd.lock) cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT: state_d = RESP;
            RESP: begin
                if (lock_go) begin
                    state_d = GRANT;
                    cmd_d   = sel_cmd;
                    ok_d    = sel_ok;
                    if (sel_cmd.lock) cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them immediately.
    always_comb begin
        bus.gnt    = '0;
        bus.rvalid = '0;
        bus.err    = 1'b0;
        bus.rdata  = '0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        case (state_q)
            GRANT: begin
                bus.gnt = NUM_REQ'(1) << win_q;
                if (ok_q) begin
                    ram_addr  = cmd_q.addr;
                    ram_we    = cmd_q.we;
                    ram_wdata = cmd_q.wdata;
                end
            end
            RESP: begin
                bus.rvalid = NUM_REQ'(1) << win_q;
                bus.err    = !ok_q;
                if (ok_q && !cmd_q.we) bus.rdata = ram_q;
            end
            default: ;
        endcase
    end

endmodule
